ahb_uart_master: RTL and testbench

- UART-driven AHB-Lite bus master used for board bring-up, boot loading and debug.
- A host PC sends command frames over the serial link. The uart_rx byte stream feeds this block, which issues single-word AHB-Lite transfers into the AHBLITE_SYS fabric and returns status or read data through uart_tx.
- It is the initiator side of the AHB interface that AHB2MEM, AHBGPIO and the other slaves respond to.

---
 rtl/ahb_uart_master.sv | 171 +++++++++++++++++
 tb/tb_ahb_uart_master.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_uart_master.sv
// UART-command-driven AHB-Lite master: decodes W/R frames from the rx byte stream,
// issues one single-word transfer, and streams the status or read data back to uart_tx.
module ahb_uart_master #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        busy,
    output logic        rx_overrun,
    output logic [2:0]  o_dbg_state
);
    // Handshakes: rx_valid is a one-cycle strobe with no back-pressure; a tx byte moves on
    // any cycle with tx_valid & tx_ready, and tx_valid/tx_data hold steady until then.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        AHB_ADDR = 3'd3,
        AHB_DATA = 3'd4,
        SEND     = 3'd5
    } state_t;

    localparam logic [7:0]       CMD_W      = 8'h57;
    localparam logic [7:0]       CMD_R      = 8'h52;
    localparam logic [7:0]       RSP_OK     = 8'h4B;
    localparam logic [7:0]       RSP_ERR    = 8'h45;
    localparam logic [7:0]       RSP_UNK    = 8'h3F;
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_byte_cnt;
    logic             r_is_write;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_tx_buf;
    logic [2:0]       r_tx_left;
    logic [CNT_W-1:0] r_timer;
    logic             r_overrun;
    logic             w_timeout;
    logic             w_field_done;

    // An arriving byte always beats a timeout in the same cycle.
    assign w_timeout    = (r_timer == TIMER_LAST) && !rx_valid;
    assign w_field_done = rx_valid && (r_byte_cnt == 2'd3);

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        HTRANS       = 2'b00;
        HWRITE       = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_W || rx_data == CMD_R) w_state_next = GET_ADDR;
                    else                                      w_state_next = SEND;
                end
            end
            GET_ADDR: begin
                if (w_field_done) begin
                    if (r_is_write) w_state_next = GET_DATA;
                    else            w_state_next = AHB_ADDR;
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            GET_DATA: begin
                if (w_field_done)   w_state_next = AHB_ADDR;
                else if (w_timeout) w_state_next = IDLE;
            end
            AHB_ADDR: begin
                HTRANS = 2'b10;
                HWRITE = r_is_write;
                if (HREADY) w_state_next = AHB_DATA;
            end
            AHB_DATA: begin
                if (HREADY) w_state_next = SEND;
            end
            SEND: begin
                if (tx_ready && r_tx_left == 3'd1) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_byte_cnt <= 2'd0;
            r_is_write <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_tx_buf   <= 32'h0;
            r_tx_left  <= 3'd0;
            r_timer    <= '0;
            r_overrun  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rx_valid) begin
                        r_is_write <= (rx_data == CMD_W);
                        r_byte_cnt <= 2'd0;
                        r_timer    <= '0;
                        r_tx_buf   <= {RSP_UNK, 24'h0};
                        r_tx_left  <= 3'd1;
                    end
                end
                GET_ADDR, GET_DATA: begin
                    if (rx_valid) begin
                        if (r_state == GET_ADDR) r_addr  <= {r_addr[23:0], rx_data};
                        else                     r_wdata <= {r_wdata[23:0], rx_data};
                        // Wraps to 0 on the 4th byte, ready for the next field.
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_timer    <= '0;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
                AHB_DATA: begin
                    if (HREADY) begin
                        if (HRESP) begin
                            r_tx_buf  <= {RSP_ERR, 24'h0};
                            r_tx_left <= 3'd1;
                        end else if (r_is_write) begin
                            r_tx_buf  <= {RSP_OK, 24'h0};
                            r_tx_left <= 3'd1;
                        end else begin
                            r_tx_buf  <= HRDATA;
                            r_tx_left <= 3'd4;
                        end
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        r_tx_buf  <= {r_tx_buf[23:0], 8'h00};
                        r_tx_left <= r_tx_left - 3'd1;
                    end
                end
                default: ;
            endcase
            if (rx_valid && (r_state == AHB_ADDR || r_state == AHB_DATA || r_state == SEND))
                r_overrun <= 1'b1;
        end
    end

    assign HADDR       = {r_addr[31:2], 2'b00};
    assign HSIZE       = 3'b010;
    assign HWDATA      = r_wdata;
    assign tx_valid    = (r_state == SEND);
    assign tx_data     = r_tx_buf[31:24];
    assign busy        = (r_state != IDLE);
    assign rx_overrun  = r_overrun;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_ahb_uart_master.sv
// Bench for ahb_uart_master: directed vector table, hand sequences for timeout/overrun/reset,
// and random frames checked against a frame-level reference model with an AHB slave model.
module tb_ahb_uart_master;
    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = 32'h0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic        busy;
    logic        rx_overrun;
    logic [2:0]  o_dbg_state;

    int checks = 0;
    int failures = 0;

    ahb_uart_master #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .busy(busy), .rx_overrun(rx_overrun), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- AHB slave model + bus / tx monitor ----------------
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ahb_t;

    int          slv_waits = 0;
    bit          slv_err = 0;
    int          addr_stall = 0;
    bit          dph = 0;
    int          wleft = 0;
    logic        dph_write = 1'b0;
    logic [31:0] dph_addr = 32'h0;
    bit          prev_stall = 0;
    logic [31:0] prev_addr = 32'h0;
    logic        prev_write = 1'b0;
    int          aphase_cycles = 0;
    logic [31:0] mem [logic [31:0]];
    ahb_t        got_ahb_q[$];
    logic [7:0]  got_tx_q[$];

    always @(negedge CLK) begin
        if (RESET) begin
            dph = 0;
            HREADY = 1'b1;
            HRESP = 1'b0;
            prev_stall = 0;
        end else begin
            chk("htrans_legal", 64'(HTRANS == 2'b00 || HTRANS == 2'b10), 64'd1);
            chk("hsize", 64'(HSIZE), 64'd2);
            if (prev_stall)
                chk("aphase_hold", {HTRANS, HWRITE, HADDR}, {2'b10, prev_write, prev_addr});
            prev_stall = 0;
            if (dph) begin
                if (wleft > 0) begin
                    HREADY = 1'b0;
                    wleft--;
                end else begin
                    HREADY = 1'b1;
                    HRESP = slv_err;
                    HRDATA = (!dph_write && mem.exists(dph_addr)) ? mem[dph_addr] : 32'h0;
                    if (dph_write && !slv_err) mem[dph_addr] = HWDATA;
                    got_ahb_q.push_back(ahb_t'{dph_write, dph_addr, dph_write ? HWDATA : 32'h0});
                    dph = 0;
                end
            end else begin
                HRESP = 1'b0;
                HREADY = 1'b1;
                if (HTRANS == 2'b10) begin
                    aphase_cycles++;
                    if (addr_stall > 0) begin
                        HREADY = 1'b0;
                        addr_stall--;
                        prev_stall = 1;
                        prev_addr = HADDR;
                        prev_write = HWRITE;
                    end else begin
                        dph = 1;
                        wleft = slv_waits;
                        dph_write = HWRITE;
                        dph_addr = HADDR;
                    end
                end
            end
            if (tx_valid && tx_ready) got_tx_q.push_back(tx_data);
        end
    end

    // ---------------- driver tasks ----------------
    logic [7:0] frame_q[$];

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int min_gap, input int max_gap);
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i]);
            if (i < frame_q.size() - 1) repeat ($urandom_range(max_gap, min_gap)) tick();
        end
    endtask

    task automatic wait_idle(input bit rand_ready);
        int n;
        n = 0;
        while (busy && n < 500) begin
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        tx_ready = 1'b1;
        chk("idle_budget", 64'(n < 500), 64'd1);
    endtask

    // ---------------- scoreboard and reference model ----------------
    logic [7:0]  exp_q[$];
    ahb_t        exp_ahb_q[$];
    logic [31:0] model_mem [logic [31:0]];

    task automatic model_frame(input bit err);
        logic [31:0] a;
        logic [31:0] d;
        if (frame_q[0] == 8'h57 || frame_q[0] == 8'h52) begin
            a = {frame_q[1], frame_q[2], frame_q[3], frame_q[4]} & 32'hFFFF_FFFC;
            if (frame_q[0] == 8'h57) begin
                d = {frame_q[5], frame_q[6], frame_q[7], frame_q[8]};
                exp_ahb_q.push_back(ahb_t'{1'b1, a, d});
                if (err) exp_q.push_back(8'h45);
                else begin
                    model_mem[a] = d;
                    exp_q.push_back(8'h4B);
                end
            end else begin
                exp_ahb_q.push_back(ahb_t'{1'b0, a, 32'h0});
                if (err) exp_q.push_back(8'h45);
                else begin
                    d = model_mem.exists(a) ? model_mem[a] : 32'h0;
                    for (int k = 3; k >= 0; k--) exp_q.push_back(d[8*k +: 8]);
                end
            end
        end else begin
            exp_q.push_back(8'h3F);
        end
    endtask

    task automatic check_frame(input string tag);
        ahb_t g;
        ahb_t e;
        chk({tag, "_txlen"}, 64'(got_tx_q.size()), 64'(exp_q.size()));
        while (got_tx_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_txbyte"}, 64'(got_tx_q.pop_front()), 64'(exp_q.pop_front()));
        chk({tag, "_ahbn"}, 64'(got_ahb_q.size()), 64'(exp_ahb_q.size()));
        while (got_ahb_q.size() > 0 && exp_ahb_q.size() > 0) begin
            g = got_ahb_q.pop_front();
            e = exp_ahb_q.pop_front();
            chk({tag, "_ahb_addr"}, {g.wr, g.addr}, {e.wr, e.addr});
            chk({tag, "_ahb_wdata"}, 64'(g.wdata), 64'(e.wdata));
        end
        chk({tag, "_state"}, 64'(o_dbg_state), 64'd0);
        got_tx_q.delete();
        exp_q.delete();
        got_ahb_q.delete();
        exp_ahb_q.delete();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_state"}, 64'(o_dbg_state), 64'd0);
        chk({tag, "_htrans"}, 64'(HTRANS), 64'd0);
        chk({tag, "_hwrite"}, 64'(HWRITE), 64'd0);
        chk({tag, "_haddr"}, 64'(HADDR), 64'd0);
        chk({tag, "_hwdata"}, 64'(HWDATA), 64'd0);
        chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        chk({tag, "_tx_data"}, 64'(tx_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_overrun"}, 64'(rx_overrun), 64'd0);
    endtask

    task automatic push_bytes(input logic [71:0] v, input int n);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(v[71-8*i -: 8]);
    endtask

    task automatic push_exp(input logic [31:0] v, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(v[31-8*k -: 8]);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [3:0]  len;
        logic [71:0] bytes;
        logic [3:0]  waits;
        logic        err;
        logic [2:0]  exp_n;
        logic [31:0] exp;
        logic        exp_xfer;
        logic        exp_wr;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind;
        int          n;
        logic [31:0] a;
        logic [31:0] d;
        logic [7:0]  b;

        vecs[0] = '{len: 4'd9, bytes: 72'h57_20000010_DEADBEEF, waits: 4'd0, err: 1'b0,
                    exp_n: 3'd1, exp: 32'h4B000000, exp_xfer: 1'b1, exp_wr: 1'b1,
                    exp_addr: 32'h20000010, exp_wdata: 32'hDEADBEEF};
        vecs[1] = '{len: 4'd9, bytes: 72'h57_20000013_12345678, waits: 4'd1, err: 1'b0,
                    exp_n: 3'd1, exp: 32'h4B000000, exp_xfer: 1'b1, exp_wr: 1'b1,
                    exp_addr: 32'h20000010, exp_wdata: 32'h12345678};
        vecs[2] = '{len: 4'd5, bytes: 72'h52_20000013_00000000, waits: 4'd3, err: 1'b0,
                    exp_n: 3'd4, exp: 32'h12345678, exp_xfer: 1'b1, exp_wr: 1'b0,
                    exp_addr: 32'h20000010, exp_wdata: 32'h0};
        vecs[3] = '{len: 4'd5, bytes: 72'h52_20000013_00000000, waits: 4'd3, err: 1'b1,
                    exp_n: 3'd1, exp: 32'h45000000, exp_xfer: 1'b1, exp_wr: 1'b0,
                    exp_addr: 32'h20000010, exp_wdata: 32'h0};
        vecs[4] = '{len: 4'd1, bytes: 72'h41_00000000_00000000, waits: 4'd0, err: 1'b0,
                    exp_n: 3'd1, exp: 32'h3F000000, exp_xfer: 1'b0, exp_wr: 1'b0,
                    exp_addr: 32'h0, exp_wdata: 32'h0};
        vecs[5] = '{len: 4'd9, bytes: 72'h57_20000020_CAFEF00D, waits: 4'd2, err: 1'b1,
                    exp_n: 3'd1, exp: 32'h45000000, exp_xfer: 1'b1, exp_wr: 1'b1,
                    exp_addr: 32'h20000020, exp_wdata: 32'hCAFEF00D};

        repeat (3) tick();
        check_reset("reset");
        RESET = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            push_bytes(vecs[v].bytes, int'(vecs[v].len));
            push_exp(vecs[v].exp, int'(vecs[v].exp_n));
            if (vecs[v].exp_xfer)
                exp_ahb_q.push_back(ahb_t'{vecs[v].exp_wr, vecs[v].exp_addr, vecs[v].exp_wdata});
            slv_waits = int'(vecs[v].waits);
            slv_err = vecs[v].err;
            aphase_cycles = 0;
            send_frame(0, 0);
            chk($sformatf("v%0d_latency", v), 64'(HTRANS), vecs[v].exp_xfer ? 64'd2 : 64'd0);
            wait_idle(0);
            chk($sformatf("v%0d_aphase", v), 64'(aphase_cycles), 64'(vecs[v].exp_xfer));
            check_frame($sformatf("v%0d", v));
        end
        slv_waits = 0;
        slv_err = 0;

        // address phase stretched by HREADY low: HTRANS/HADDR/HWRITE must hold
        addr_stall = 2;
        aphase_cycles = 0;
        push_bytes(72'h57_20000030_11223344, 9);
        push_exp(32'h4B000000, 1);
        exp_ahb_q.push_back(ahb_t'{1'b1, 32'h20000030, 32'h11223344});
        send_frame(0, 0);
        wait_idle(0);
        chk("stall_aphase", 64'(aphase_cycles), 64'd3);
        check_frame("stall");

        // inter-byte timeout discards a partial frame
        push_bytes(72'h57_20_00000000_000000, 2);
        send_frame(0, 0);
        repeat (20) tick();
        chk("to_busy", 64'(busy), 64'd0);
        check_frame("timeout");
        push_bytes(72'h52_20000010_00000000, 5);
        push_exp(32'h12345678, 4);
        exp_ahb_q.push_back(ahb_t'{1'b0, 32'h20000010, 32'h0});
        send_frame(0, 0);
        wait_idle(0);
        check_frame("after_to");

        // gaps just under the timeout keep the frame alive
        push_bytes(72'h52_20000030_00000000, 5);
        push_exp(32'h11223344, 4);
        exp_ahb_q.push_back(ahb_t'{1'b0, 32'h20000030, 32'h0});
        send_frame(TO - 2, TO - 2);
        wait_idle(0);
        check_frame("slow_gap");

        // overrun: byte arrives while the reply is stalled
        tx_ready = 1'b0;
        push_bytes(72'h52_20000010_00000000, 5);
        push_exp(32'h12345678, 4);
        exp_ahb_q.push_back(ahb_t'{1'b0, 32'h20000010, 32'h0});
        send_frame(0, 0);
        n = 0;
        while (!tx_valid && n < 50) begin
            tick();
            n++;
        end
        chk("ovr_txvalid", 64'(tx_valid), 64'd1);
        chk("ovr_before", 64'(rx_overrun), 64'd0);
        send_byte(8'h41);
        chk("ovr_set", 64'(rx_overrun), 64'd1);
        chk("ovr_state", 64'(o_dbg_state), 64'd5);
        chk("ovr_txhold", 64'(tx_data), 64'h12);
        wait_idle(0);
        check_frame("overrun");
        chk("ovr_sticky", 64'(rx_overrun), 64'd1);

        // reset mid GET_DATA
        push_bytes(72'h57_20000040_AABB0000, 7);
        send_frame(0, 0);
        chk("rst_gd_state", 64'(o_dbg_state), 64'd2);
        RESET = 1'b1;
        tick();
        check_reset("rst_gd");
        RESET = 1'b0;

        // reset while the AHB data phase is still waiting
        slv_waits = 10;
        push_bytes(72'h52_20000010_00000000, 5);
        send_frame(0, 0);
        tick();
        chk("rst_dp_state", 64'(o_dbg_state), 64'd4);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_reset("rst_dp");
        repeat (15) tick();
        slv_waits = 0;
        check_frame("rst_dp_quiet");

        // random frames against the reference model
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 8);
            a = 32'h4000_0000 | 32'($urandom_range(0, 63));
            d = $urandom;
            frame_q.delete();
            if (kind < 8) begin
                frame_q.push_back(kind < 4 ? 8'h57 : 8'h52);
                for (int k = 3; k >= 0; k--) frame_q.push_back(a[8*k +: 8]);
                if (kind < 4) for (int k = 3; k >= 0; k--) frame_q.push_back(d[8*k +: 8]);
            end else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h57 || b == 8'h52) b = 8'h00;
                frame_q.push_back(b);
            end
            slv_err = ($urandom_range(0, 5) == 0);
            slv_waits = $urandom_range(0, 3);
            addr_stall = $urandom_range(0, 2);
            model_frame(slv_err);
            send_frame(0, 3);
            wait_idle(1);
            check_frame($sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
